// File: rtl/uart_packet_rx.sv
// uart_packet_rx: 8N1 UART receiver that frames bytes into fixed-length scene packets.
// Define PKT_CHECKSUM_EN to expect one trailing mod-256 checksum byte per packet.
module uart_packet_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int PKT_LEN      = 60,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] read_data,
  output logic [6:0] idx,
  output logic       update_reg,
  output logic       pc_ready,
  output logic       frame_err,
  output logic       busy
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            TW        = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1     = TW'(TO_CYCLES - 1);
  localparam logic [6:0]    LAST_IDX  = 7'(PKT_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [6:0]    r_count;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_read_data;
  logic [6:0]    r_idx;
  logic          r_update;
  logic          r_pc_ready;
  logic          r_frame_err;
  logic          w_tick;
  logic          w_start_det;
  logic          w_accept;
  logic          w_bad_stop;
  logic          w_to_run;
  logic          w_to_expire;
`ifdef PKT_CHECKSUM_EN
  localparam logic [6:0] CSUM_IDX = 7'(PKT_LEN);
  logic [7:0] r_sum;
  logic [7:0] w_sum_total;
  assign w_sum_total = r_sum + r_shift;
`else
  logic r_pc_pend;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_tick       = 1'b0;
    w_start_det  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_start_det  = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (r_clk_cnt == HALF_M1) begin
          w_tick       = 1'b1;
          w_state_next = r_rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == FULL_M1) begin
          w_tick = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == FULL_M1) begin
          w_tick       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept    = (r_state == S_STOP) && w_tick && r_rx_sync;
  assign w_bad_stop  = (r_state == S_STOP) && w_tick && !r_rx_sync;
  assign w_to_run    = (r_state == S_IDLE) && (r_count != 7'd0) && !w_start_det;
  assign w_to_expire = w_to_run && (r_to_cnt == TO_M1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_state   <= w_state_next;
      r_clk_cnt <= (r_state == S_IDLE || w_tick) ? '0 : r_clk_cnt + 1'b1;
      if (r_state != S_DATA) r_bit_cnt <= 3'd0;
      else if (w_tick)       r_bit_cnt <= r_bit_cnt + 3'd1;
      if (r_state == S_DATA && w_tick) r_shift <= {r_rx_sync, r_shift[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 7'd0;
      r_to_cnt    <= '0;
      r_read_data <= 8'd0;
      r_idx       <= 7'd0;
      r_update    <= 1'b0;
      r_pc_ready  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      r_sum       <= 8'd0;
`else
      r_pc_pend   <= 1'b0;
`endif
    end else begin
      r_update    <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      r_pc_ready  <= 1'b0;
`else
      // pc_ready trails the final update_reg by one cycle so the two never coincide.
      r_pc_ready  <= r_pc_pend;
      r_pc_pend   <= 1'b0;
`endif
      r_to_cnt <= (!w_to_run || w_to_expire) ? '0 : r_to_cnt + 1'b1;

      if (w_bad_stop) begin
        r_frame_err <= 1'b1;
        r_count     <= 7'd0;
      end else if (w_accept) begin
`ifdef PKT_CHECKSUM_EN
        if (r_count == CSUM_IDX) begin
          r_count <= 7'd0;
          if (w_sum_total == 8'd0) r_pc_ready  <= 1'b1;
          else                     r_frame_err <= 1'b1;
        end else begin
          r_read_data <= r_shift;
          r_idx       <= r_count;
          r_update    <= 1'b1;
          r_sum       <= (r_count == 7'd0) ? r_shift : w_sum_total;
          r_count     <= r_count + 7'd1;
        end
`else
        r_read_data <= r_shift;
        r_idx       <= r_count;
        r_update    <= 1'b1;
        if (r_count == LAST_IDX) begin
          r_count   <= 7'd0;
          r_pc_pend <= 1'b1;
        end else begin
          r_count   <= r_count + 7'd1;
        end
`endif
      end else if (w_to_expire) begin
        r_count <= 7'd0;
      end
    end
  end

  assign read_data  = r_read_data;
  assign idx        = r_idx;
  assign update_reg = r_update;
  assign pc_ready   = r_pc_ready;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != S_IDLE) || (r_count != 7'd0);

endmodule

// File: doc/uart_packet_rx.md
# uart_packet_rx

Serial front end of the tiniest GPU. Receives the 8N1 UART byte stream from the host PC and frames it into fixed-length scene packets. Presents each byte with its packet index as a one-cycle write strobe to the top-level scene register file. Signals packet completion so the vertex stage starts a new setup.

## Interface
Parameters:
- CLKS_PER_BIT, 217, clk cycles per UART bit (25 MHz / 115200); must be ≥ 8.
- PKT_LEN, 60, data bytes per packet; range 2..127.
- TIMEOUT_BITS, 32, idle bit-times mid-packet before the packet is abandoned.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- rx  in  1  asynchronous UART line; idles high.
- read_data  out  8  last accepted data byte; held until the next accepted byte.
- idx  out  7  packet index of read_data, 0..PKT_LEN-1.
- update_reg  out  1  one-cycle strobe; read_data/idx are valid in that cycle.
- pc_ready  out  1  one-cycle strobe; a complete packet was received.
- frame_err  out  1  one-cycle strobe; bad stop bit, or bad checksum when the checksum feature is compiled in.
- busy  out  1  high while a byte is being received or the packet count is nonzero.

## Operation
- rx passes through a 2-flop synchronizer. Start detection uses the synchronized value.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronized high→low transition.
  - START samples at CLKS_PER_BIT/2. If the sample is high, it is a false start: return to IDLE with no output.
  - DATA takes 8 samples, each CLKS_PER_BIT apart, LSB first.
  - STOP takes one sample. A 1 accepts the byte. A 0 pulses frame_err, discards the byte, and clears the packet count. Both cases return to IDLE.
- Packet layer: 7-bit count, 0 after reset.
  - On an accepted byte: read_data←byte, idx←count, update_reg pulse, then count increments.
  - The byte with count = PKT_LEN-1 wraps count to 0 and schedules pc_ready.
- Inter-byte timeout:
  - While count ≠ 0 and the bit FSM is in IDLE, a counter runs. It resets on every start detection.
  - After TIMEOUT_BITS×CLKS_PER_BIT cycles, count clears to 0. No pc_ready and no frame_err are issued.
- update_reg and pc_ready are never asserted in the same cycle.
- busy = (bit FSM ≠ IDLE) | (count ≠ 0).

## Timing
- Reset values: read_data 0, idx 0, update_reg 0, pc_ready 0, frame_err 0, busy 0. Bit FSM is IDLE; count and timeout counter are 0.
- Reset asserted mid-byte or mid-packet aborts everything immediately. No strobes are issued in the cycle after reset.
- Latency:
  - update_reg is registered and asserts the cycle after the stop-bit mid-sample.
  - pc_ready asserts the cycle after the final update_reg.
- Start edge to update_reg ≈ 9.5×CLKS_PER_BIT + 3 cycles, including the synchronizer.
- A new start bit may be detected in the same cycle as update_reg or pc_ready; no byte is lost back-to-back.
- The timeout counter is wide enough for TIMEOUT_BITS×CLKS_PER_BIT without overflow.

## Configuration
- PKT_CHECKSUM_EN, defined:
  - Each packet carries one extra trailing byte, for PKT_LEN+1 total on the wire.
  - Check rule: the mod-256 sum of the PKT_LEN data bytes plus the checksum byte must equal 0x00.
  - The checksum byte produces no update_reg.
  - Good sum: pc_ready pulses the cycle after the checksum stop bit.
  - Bad sum: frame_err pulses instead, and count returns to 0. Registers already written stay written; the vertex stage is simply not triggered.
- PKT_CHECKSUM_EN, undefined: no checksum byte is expected. pc_ready follows the data byte at idx PKT_LEN-1.

## Test plan
- CLKS_PER_BIT=16; send byte 0xA5 → exactly one update_reg, read_data=0xA5, idx=0, busy=1 afterwards, no pc_ready.
- Send bytes 0x00..0x3B back-to-back → 60 update_reg pulses with idx=read_data=0..59. Exactly one pc_ready, one cycle after the idx=59 strobe; busy=0 after it.
- Drive rx low for 4 clk, then high → no update_reg, no frame_err; the next valid byte gets idx=0.
- After 5 good bytes, send 0x77 with stop bit 0 → frame_err pulse, no update_reg. The next good byte gets idx=0.
- Send 10 bytes, hold rx high for 40 bit-times → count clears, no pc_ready. The next byte gets idx=0.
- With PKT_CHECKSUM_EN and bytes 0x01×60:
  - Checksum 0xC4 → pc_ready.
  - Checksum 0xC5 → frame_err, no pc_ready.
